// File: rtl/knn_kbest_selector.sv
// K-best selector: scans the distance buffer and keeps the K nearest
// samples in an ascending list with a registered read port.
module knn_kbest_selector #(
    parameter int NUM_SAMPLES = 100,
    parameter int K_MAX       = 8,
    parameter int DIST_WIDTH  = 20,
    parameter int LABEL_WIDTH = 4,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sort_start,
    input  logic                     sort_clear,
    input  logic                     en_sort,
    input  logic [ADDR_WIDTH-1:0]    k_value,
    input  logic [ADDR_WIDTH-1:0]    num_samples,
    output logic                     dist_ren,
    output logic [ADDR_WIDTH-1:0]    dist_raddr,
    input  logic [DIST_WIDTH-1:0]    dist_rdata,
    input  logic [LABEL_WIDTH-1:0]   dist_rlabel,
    output logic                     sort_done,
    output logic                     busy,
    input  logic                     kbest_ren,
    input  logic [$clog2(K_MAX)-1:0] kbest_raddr,
    output logic [DIST_WIDTH-1:0]    kbest_dist,
    output logic [LABEL_WIDTH-1:0]   kbest_label,
    output logic [ADDR_WIDTH-1:0]    kbest_idx,
    output logic [ADDR_WIDTH-1:0]    kbest_count
);

    localparam logic [ADDR_WIDTH-1:0] KMAX_A   = ADDR_WIDTH'(K_MAX);
    localparam logic [ADDR_WIDTH-1:0] NMAX_A   = ADDR_WIDTH'(NUM_SAMPLES);
    localparam logic [DIST_WIDTH-1:0] DIST_INF = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_READ,
        S_INSERT,
        S_DONE,
        S_HELD
    } state_t;

    state_t                  state_q, state_d;
    logic                    start_prev_q;
    logic [ADDR_WIDTH-1:0]   i_q, i_d;
    logic [ADDR_WIDTH-1:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0]   keff_q, keff_d;
    logic [ADDR_WIDTH-1:0]   nsmp_q, nsmp_d;
    logic [DIST_WIDTH-1:0]   slot_dist_q  [K_MAX];
    logic [DIST_WIDTH-1:0]   slot_dist_d  [K_MAX];
    logic [LABEL_WIDTH-1:0]  slot_label_q [K_MAX];
    logic [LABEL_WIDTH-1:0]  slot_label_d [K_MAX];
    logic [ADDR_WIDTH-1:0]   slot_idx_q   [K_MAX];
    logic [ADDR_WIDTH-1:0]   slot_idx_d   [K_MAX];
    logic [DIST_WIDTH-1:0]   rd_dist_q;
    logic [LABEL_WIDTH-1:0]  rd_label_q;
    logic [ADDR_WIDTH-1:0]   rd_idx_q;

    logic                    start_edge;
    logic [ADDR_WIDTH-1:0]   pos;
    logic [ADDR_WIDTH-1:0]   i_inc;

    assign start_edge = sort_start & ~start_prev_q;
    assign i_inc      = i_q + ADDR_WIDTH'(1);

    // Insert position: valid slots form a sorted prefix, so counting
    // entries <= operand keeps equal distances in arrival order.
    always_comb begin
        pos = '0;
        for (int j = 0; j < K_MAX; j++) begin
            if ((ADDR_WIDTH'(j) < count_q) && (slot_dist_q[j] <= dist_rdata)) begin
                pos = pos + ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        count_d      = count_q;
        keff_d       = keff_q;
        nsmp_d       = nsmp_q;
        slot_dist_d  = slot_dist_q;
        slot_label_d = slot_label_q;
        slot_idx_d   = slot_idx_q;
        dist_ren     = 1'b0;
        dist_raddr   = '0;
        busy         = 1'b0;
        sort_done    = 1'b0;

        unique case (state_q)
            S_IDLE, S_HELD: begin
                if (start_edge) begin
                    state_d = S_CLEAR;
                    keff_d  = (k_value > KMAX_A) ? KMAX_A : k_value;
                    nsmp_d  = (num_samples > NMAX_A) ? NMAX_A : num_samples;
                end
            end
            S_CLEAR: begin
                busy    = 1'b1;
                count_d = '0;
                i_d     = '0;
                for (int j = 0; j < K_MAX; j++) begin
                    slot_dist_d[j]  = DIST_INF;
                    slot_label_d[j] = '0;
                    slot_idx_d[j]   = '0;
                end
                if ((nsmp_q == '0) || (keff_q == '0)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                busy       = 1'b1;
                dist_raddr = i_q;
                if (en_sort) begin
                    dist_ren = 1'b1;
                    state_d  = S_INSERT;
                end
            end
            S_INSERT: begin
                busy = 1'b1;
                if (pos < keff_q) begin
                    for (int j = 1; j < K_MAX; j++) begin
                        if ((ADDR_WIDTH'(j) > pos) && (ADDR_WIDTH'(j) < keff_q)) begin
                            slot_dist_d[j]  = slot_dist_q[j-1];
                            slot_label_d[j] = slot_label_q[j-1];
                            slot_idx_d[j]   = slot_idx_q[j-1];
                        end
                    end
                    for (int j = 0; j < K_MAX; j++) begin
                        if (ADDR_WIDTH'(j) == pos) begin
                            slot_dist_d[j]  = dist_rdata;
                            slot_label_d[j] = dist_rlabel;
                            slot_idx_d[j]   = i_q;
                        end
                    end
                    if (count_q < keff_q) begin
                        count_d = count_q + ADDR_WIDTH'(1);
                    end
                end
                i_d = i_inc;
                if (i_inc == nsmp_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                sort_done = 1'b1;
                state_d   = S_HELD;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush has priority over everything, including a same-cycle start.
        if (sort_clear) begin
            state_d    = S_IDLE;
            count_d    = '0;
            dist_ren   = 1'b0;
            dist_raddr = '0;
            busy       = 1'b0;
            sort_done  = 1'b0;
            for (int j = 0; j < K_MAX; j++) begin
                slot_dist_d[j]  = DIST_INF;
                slot_label_d[j] = '0;
                slot_idx_d[j]   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            i_q          <= '0;
            count_q      <= '0;
            keff_q       <= '0;
            nsmp_q       <= '0;
            for (int j = 0; j < K_MAX; j++) begin
                slot_dist_q[j]  <= DIST_INF;
                slot_label_q[j] <= '0;
                slot_idx_q[j]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            start_prev_q <= sort_start;
            i_q          <= i_d;
            count_q      <= count_d;
            keff_q       <= keff_d;
            nsmp_q       <= nsmp_d;
            slot_dist_q  <= slot_dist_d;
            slot_label_q <= slot_label_d;
            slot_idx_q   <= slot_idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dist_q  <= '0;
            rd_label_q <= '0;
            rd_idx_q   <= '0;
        end else if (kbest_ren) begin
            if (ADDR_WIDTH'(kbest_raddr) < count_q) begin
                rd_dist_q  <= slot_dist_q[kbest_raddr];
                rd_label_q <= slot_label_q[kbest_raddr];
                rd_idx_q   <= slot_idx_q[kbest_raddr];
            end else begin
                rd_dist_q  <= DIST_INF;
                rd_label_q <= '0;
                rd_idx_q   <= '0;
            end
        end
    end

    assign kbest_dist  = rd_dist_q;
    assign kbest_label = rd_label_q;
    assign kbest_idx   = rd_idx_q;
    assign kbest_count = count_q;

endmodule

// File: doc/knn_kbest_selector.md
Name: knn_kbest_selector

Overview:
- Sort / k-best stage of the KNN classifier. Sits downstream of distance calculation and upstream of majority voting.
- On a start request it scans the stored distance buffer (distance plus training label per sample). It keeps the K smallest entries in an ascending on-chip list, then signals completion.
- Exposes a registered read port so the control unit and majority voter can fetch the k-th nearest neighbour's distance, label and sample index.

Parameters:
- NUM_SAMPLES, 100, maximum training samples scanned
- K_MAX, 8, physical depth of the k-best list
- DIST_WIDTH, 20, distance word width (unsigned)
- LABEL_WIDTH, 4, class label width
- ADDR_WIDTH, 8, sample address / count width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- sort_start  in  1  start request; rising edge is the trigger
- sort_clear  in  1  synchronous abort/flush
- en_sort  in  1  scan enable; low stalls new reads
- k_value  in  ADDR_WIDTH  requested K
- num_samples  in  ADDR_WIDTH  samples to scan
- dist_ren  out  1  distance buffer read enable
- dist_raddr  out  ADDR_WIDTH  distance buffer address
- dist_rdata  in  DIST_WIDTH  distance, valid 1 cycle after dist_ren
- dist_rlabel  in  LABEL_WIDTH  label stored with that distance, same timing
- sort_done  out  1  one-cycle completion pulse
- busy  out  1  scan in progress
- kbest_ren  in  1  k-best read enable
- kbest_raddr  in  $clog2(K_MAX)  slot index, 0 = nearest
- kbest_dist  out  DIST_WIDTH  slot distance
- kbest_label  out  LABEL_WIDTH  slot label
- kbest_idx  out  ADDR_WIDTH  slot sample index
- kbest_count  out  ADDR_WIDTH  number of valid slots

Behaviour:
- Reset (rst_n low, async): state IDLE. All slots invalid; slot dist all-ones, label 0, idx 0. All outputs 0: dist_ren, dist_raddr, sort_done, busy, kbest_dist, kbest_label, kbest_idx, kbest_count. sort_start edge-detect register cleared.
- Start trigger: sort_start high with registered previous value low, while in IDLE or HELD. A level held high never retriggers. Start edges seen in CLEAR/READ/INSERT are ignored.
- Keff = min(k_value, K_MAX). num_samples is clamped to NUM_SAMPLES.
- FSM states:
  - IDLE
  - CLEAR: 1 cycle; invalidate all slots; count=0; sample index i=0; busy=1.
  - READ: dist_ren=1, dist_raddr=i (combinational from state/i). If en_sort=0, stay in READ with dist_ren=0.
  - INSERT: 1 cycle; always completes regardless of en_sort. Operand = (dist_rdata, dist_rlabel, i).
    - Find position p = number of valid slots with dist <= operand. Ties: earlier sample stays nearer.
    - If p < Keff, shift slots p..Keff-2 down by one, write operand at p, count = min(count+1, Keff). Otherwise discard.
    - Then i+1. If i+1 == num_samples go to DONE, else READ.
  - DONE: sort_done=1 for exactly this cycle, busy=0, then HELD.
  - HELD: list retained; behaves as IDLE for start and clear.
- CLEAR exits to DONE directly if num_samples==0 or Keff==0, leaving count 0.
- Latency with en_sort held high: sort_done is high in the cycle after the (2N+2)-th rising edge counted from the edge that samples the start (N = clamped num_samples).
- sort_clear (sampled high):
  - Overrides every state: invalidate slots, count=0, go to IDLE, dist_ren=0, busy=0, no sort_done.
  - Simultaneous with a start edge: clear wins and the start is dropped.
- Read port: registered, 1-cycle latency on kbest_ren.
  - kbest_raddr < kbest_count returns slot contents.
  - Otherwise returns dist all-ones, label 0, idx 0.
  - Outputs hold when kbest_ren=0.
  - Reads during a scan return the current partial list; this is legal.
- Arithmetic: all distance comparisons are unsigned DIST_WIDTH. Index counter is ADDR_WIDTH and never wraps, because the num_samples clamp bounds it.

Test Plan:
- K=3, N=6, distances [50,10,40,10,70,5], labels [1..6] -> sort_done 14 cycles after start. Slots 0..2 = (5,lbl6,idx5), (10,lbl2,idx1), (10,lbl4,idx3). kbest_count=3.
- sort_start held high 20 cycles across completion -> exactly one scan, one sort_done pulse.
- en_sort low for 4 cycles mid-scan (N=6) -> sort_done delayed by exactly 4 cycles, same slot contents as the first test.
- sort_clear asserted during INSERT of sample 3 -> busy=0 next cycle, kbest_count=0, no sort_done, slot 0 reads dist 0xFFFFF.
- k_value=20 with K_MAX=8, N=10 distances descending 100..10 -> count=8, slot 0 = 10 idx 9, slot 7 = 80 idx 2.
- num_samples=0 -> sort_done 2 cycles after start, count 0. Then rst_n pulsed low mid-scan -> all outputs 0 immediately.
